pcf8591_txn_scheduler: RTL and testbench
========================================

// Module: pcf8591_txn_scheduler
// PURPOSE
//  Transaction scheduler for the PCF8591 ADC/DAC on the shared I2C bus. Accepts DAC-update and
//  ADC-sample requests from the application, arbitrates round-robin, and sequences each as byte
//  commands to a single i2c_byte_engine (bit-level SCL/SDA timing lives there, not here).
//  Returns ADC results and completion/error status to the requesters.
// PARAMETERS
//  DEV_ADDR   7'h48   7-bit PCF8591 address; write byte = {DEV_ADDR,1'b0}, read = {DEV_ADDR,1'b1}
//  CTRL_BASE  8'h40   control byte with analog-output enable; ADC ctrl = CTRL_BASE | {6'b0,ch}
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  synchronous active-low reset
//  dac_req      in   1  one-cycle pulse: write dac_value to DAC
//  dac_value    in   8  DAC code, sampled when dac_req=1
//  adc_req      in   1  one-cycle pulse: sample channel adc_ch
//  adc_ch       in   2  ADC channel 0..3, sampled when adc_req=1
//  dac_done     out  1  one-cycle pulse at end of DAC transaction
//  adc_valid    out  1  one-cycle pulse at end of ADC transaction
//  adc_data     out  8  last conversion result (held)
//  adc_ch_out   out  2  channel belonging to adc_data (held)
//  err          out  1  1 with dac_done/adc_valid if transaction was aborted on NACK
//  busy         out  1  transaction in progress
//  cmd_valid    out  1  command to byte engine valid
//  cmd_ready    in   1  byte engine accepts command when cmd_valid&cmd_ready
//  cmd_op       out  2  START=0, WRITE=1, READ=2, STOP=3 (START while bus held = repeated start)
//  cmd_wdata    out  8  byte for WRITE
//  cmd_mack     out  1  for READ: 1 = master ACKs, 0 = master NACKs
//  rsp_valid    in   1  one-cycle pulse: command finished
//  rsp_rdata    in   8  byte returned by READ
//  rsp_nack     in   1  WRITE was NACKed by slave (valid with rsp_valid)
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state IDLE, pending flags cleared, all outputs 0, adc_data=0,
//   adc_ch_out=0, last_grant=ADC (so DAC wins the first tie). Reset mid-transaction aborts
//   with no STOP; the byte engine shares rst_n and releases the bus.
//  Request capture: dac_req sets dac_pend and overwrites dac_val_r (latest value wins, requests
//   coalesce); adc_req likewise for adc_pend/adc_ch_r. Capture works in every state, including
//   the cycle a pending flag is being cleared (new request re-sets it).
//  Arbitration (IDLE only, one cycle): only one pending -> grant it; both -> grant the one not
//   in last_grant; update last_grant; clear granted pending flag; busy=1 from next cycle.
//  One command outstanding: drive cmd_* with cmd_valid=1 until cmd_ready; then cmd_valid=0 and
//   wait rsp_valid before next state. cmd_* stable while cmd_valid=1.
//  DAC sequence: START -> WRITE {DEV_ADDR,0} -> WRITE CTRL_BASE -> WRITE dac_val_r -> STOP
//   -> DONE (dac_done=1 one cycle) -> IDLE.
//  ADC sequence: START -> WRITE {DEV_ADDR,0} -> WRITE CTRL_BASE|ch -> START -> WRITE {DEV_ADDR,1}
//   -> READ mack=1 (stale previous conversion, discarded) -> READ mack=0 (result) -> STOP
//   -> DONE: adc_data<=result, adc_ch_out<=ch, adc_valid=1 one cycle -> IDLE.
//  NACK: rsp_nack=1 on any WRITE -> set abort flag, go to STOP, then DONE with err=1; on ADC
//   abort adc_data/adc_ch_out unchanged. err is 0 on successful DONE and whenever not DONE.
//  busy=0 only in IDLE. No timeout: a stuck engine holds busy until reset.
// STRUCTURE
//  pcf8591_pkg: cmd_op encodings, state enum, DEV_ADDR/CTRL_BASE defaults.
//  Single FSM with one shared ISSUE/WAIT sub-phase flag; no sub-module. i2c_byte_engine is
//  instantiated alongside it by the parent, not inside.
// TESTING (bench models i2c_byte_engine: random 0-5 cycle cmd_ready delay, rsp 20 cycles later)
//  dac_req value 8'h80 -> cmds START,W90,W40,W80,STOP; one dac_done, err=0, busy low after.
//  adc_req ch=2, model reads 8'h11 then 8'h5A -> cmds ...W42,START,W91,R(ack),R(nack),STOP;
//   adc_valid with adc_data=8'h5A, adc_ch_out=2.
//  dac_req and adc_req same cycle after reset -> DAC transaction first, then ADC; repeat tie
//   -> ADC first.
//  Model NACKs address byte on DAC -> next cmd STOP, dac_done with err=1, no W40 issued;
//   NACK on ADC ctrl -> adc_valid err=1, adc_data keeps prior 8'h5A.
//  dac_req 8'h10 then 8'h20 while ADC busy -> exactly one further DAC write, data 8'h20.
//  rst_n=0 during ADC READ -> next cycle cmd_valid=0, busy=0, outputs at reset values;
//   subsequent dac_req completes normally.

Source files
------------

// File: rtl/pcf8591_pkg.sv
// Shared encodings for the PCF8591 transaction scheduler: byte-engine opcodes,
// FSM states and the default device address / control byte.
package pcf8591_pkg;

    localparam logic [6:0] DEV_ADDR_DEFAULT  = 7'h48;
    localparam logic [7:0] CTRL_BASE_DEFAULT = 8'h40;

    typedef enum logic [1:0] {
        OP_START = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2,
        OP_STOP  = 2'd3
    } cmd_op_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_WADDR,
        S_WCTRL,
        S_WDATA,
        S_RSTART,
        S_RADDR,
        S_READ_ACK,
        S_READ_NACK,
        S_STOP,
        S_DONE
    } state_e;

    // DAC and ADC share the START/address/control prefix and diverge after the control byte.
    function automatic state_e next_step(input state_e s, input logic is_adc);
        case (s)
            S_START:     return S_WADDR;
            S_WADDR:     return S_WCTRL;
            S_WCTRL:     return is_adc ? S_RSTART : S_WDATA;
            S_WDATA:     return S_STOP;
            S_RSTART:    return S_RADDR;
            S_RADDR:     return S_READ_ACK;
            S_READ_ACK:  return S_READ_NACK;
            S_READ_NACK: return S_STOP;
            S_STOP:      return S_DONE;
            default:     return S_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/pcf8591_txn_scheduler.sv
// Round-robin scheduler turning DAC-update / ADC-sample requests into byte commands
// for an external i2c_byte_engine; one command outstanding at a time.
module pcf8591_txn_scheduler
    import pcf8591_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR  = DEV_ADDR_DEFAULT,
    parameter logic [7:0] CTRL_BASE = CTRL_BASE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dac_req,
    input  logic [7:0] dac_value,
    input  logic       adc_req,
    input  logic [1:0] adc_ch,
    output logic       dac_done,
    output logic       adc_valid,
    output logic [7:0] adc_data,
    output logic [1:0] adc_ch_out,
    output logic       err,
    output logic       busy,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [1:0] cmd_op,
    output logic [7:0] cmd_wdata,
    output logic       cmd_mack,
    input  logic       rsp_valid,
    input  logic [7:0] rsp_rdata,
    input  logic       rsp_nack
);

    state_e     state, state_n;
    logic       waiting, waiting_n;
    logic       abort, abort_n;
    logic       is_adc;
    logic       last_adc;
    logic       dac_pend, adc_pend;
    logic [7:0] dac_val_r;
    logic [1:0] adc_ch_r;
    logic [7:0] txn_byte;
    logic [1:0] txn_ch;
    logic [7:0] result_r;
    logic       grant_dac, grant_adc;
    logic       is_write;
    logic       take_result;
    logic       commit_adc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            waiting    <= 1'b0;
            abort      <= 1'b0;
            is_adc     <= 1'b0;
            last_adc   <= 1'b1;
            dac_pend   <= 1'b0;
            adc_pend   <= 1'b0;
            dac_val_r  <= '0;
            adc_ch_r   <= '0;
            txn_byte   <= '0;
            txn_ch     <= '0;
            result_r   <= '0;
            adc_data   <= '0;
            adc_ch_out <= '0;
        end else begin
            state   <= state_n;
            waiting <= waiting_n;
            abort   <= abort_n;
            // A request arriving on the grant cycle re-arms the flag being cleared.
            dac_pend <= dac_req | (dac_pend & ~grant_dac);
            adc_pend <= adc_req | (adc_pend & ~grant_adc);
            if (dac_req) dac_val_r <= dac_value;
            if (adc_req) adc_ch_r  <= adc_ch;
            // Snapshot the payload at grant so later requests cannot disturb cmd_* mid-flight.
            if (grant_dac || grant_adc) begin
                is_adc   <= grant_adc;
                last_adc <= grant_adc;
                txn_byte <= grant_adc ? (CTRL_BASE | {6'b0, adc_ch_r}) : dac_val_r;
                txn_ch   <= adc_ch_r;
            end
            if (take_result) result_r <= rsp_rdata;
            if (commit_adc) begin
                adc_data   <= result_r;
                adc_ch_out <= txn_ch;
            end
        end
    end

    always_comb begin
        state_n     = state;
        waiting_n   = waiting;
        abort_n     = abort;
        grant_dac   = 1'b0;
        grant_adc   = 1'b0;
        take_result = 1'b0;
        commit_adc  = 1'b0;
        cmd_valid   = 1'b0;
        cmd_op      = OP_START;
        cmd_wdata   = '0;
        cmd_mack    = 1'b0;
        dac_done    = 1'b0;
        adc_valid   = 1'b0;
        err         = 1'b0;
        busy        = (state != S_IDLE);
        is_write    = (state == S_WADDR) || (state == S_WCTRL) ||
                      (state == S_WDATA) || (state == S_RADDR);

        case (state)
            S_IDLE: begin
                if (dac_pend && (!adc_pend || last_adc)) grant_dac = 1'b1;
                else if (adc_pend)                       grant_adc = 1'b1;
                if (grant_dac || grant_adc) begin
                    state_n   = S_START;
                    waiting_n = 1'b0;
                    abort_n   = 1'b0;
                end
            end
            S_DONE: begin
                dac_done = !is_adc;
                adc_valid = is_adc;
                err       = abort;
                state_n   = S_IDLE;
            end
            default: begin
                if (!waiting) begin
                    cmd_valid = 1'b1;
                    case (state)
                        S_WADDR:     begin cmd_op = OP_WRITE; cmd_wdata = {DEV_ADDR, 1'b0}; end
                        S_WCTRL:     begin cmd_op = OP_WRITE; cmd_wdata = is_adc ? txn_byte : CTRL_BASE; end
                        S_WDATA:     begin cmd_op = OP_WRITE; cmd_wdata = txn_byte; end
                        S_RADDR:     begin cmd_op = OP_WRITE; cmd_wdata = {DEV_ADDR, 1'b1}; end
                        S_READ_ACK:  begin cmd_op = OP_READ;  cmd_mack  = 1'b1; end
                        S_READ_NACK: begin cmd_op = OP_READ;  cmd_mack  = 1'b0; end
                        S_STOP:      cmd_op = OP_STOP;
                        default:     cmd_op = OP_START;
                    endcase
                    if (cmd_ready) waiting_n = 1'b1;
                end else if (rsp_valid) begin
                    waiting_n = 1'b0;
                    if (state == S_STOP) begin
                        state_n    = S_DONE;
                        commit_adc = is_adc && !abort;
                    end else if (is_write && rsp_nack) begin
                        abort_n = 1'b1;
                        state_n = S_STOP;
                    end else begin
                        state_n = next_step(state, is_adc);
                    end
                    // Only the second, NACKed read carries the fresh conversion.
                    take_result = (state == S_READ_NACK);
                end
            end
        endcase
    end

endmodule

// File: tb/tb_pcf8591_txn_scheduler.sv
// Bench for pcf8591_txn_scheduler: byte-engine model, transaction-level expectation queues.
module tb_pcf8591_txn_scheduler;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       dac_req = 1'b0, adc_req = 1'b0;
    logic [7:0] dac_value = '0;
    logic [1:0] adc_ch = '0;
    logic       dac_done, adc_valid, err, busy, cmd_valid, cmd_mack;
    logic [7:0] adc_data, cmd_wdata;
    logic [1:0] adc_ch_out, cmd_op;
    logic       cmd_ready = 1'b0, rsp_valid = 1'b0, rsp_nack = 1'b0;
    logic [7:0] rsp_rdata = '0;

    pcf8591_txn_scheduler dut (
        .clk(clk), .rst_n(rst_n), .dac_req(dac_req), .dac_value(dac_value),
        .adc_req(adc_req), .adc_ch(adc_ch), .dac_done(dac_done), .adc_valid(adc_valid),
        .adc_data(adc_data), .adc_ch_out(adc_ch_out), .err(err), .busy(busy),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_wdata(cmd_wdata),
        .cmd_mack(cmd_mack), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] START = 2'd0, WRITE = 2'd1, READ = 2'd2, STOP = 2'd3;

    typedef struct packed { logic [1:0] op; logic [7:0] wdata; logic mack; } cmd_t;
    typedef struct packed { logic is_adc; logic err; logic [7:0] data; logic [1:0] ch; } done_t;

    cmd_t       exp_cmd[$];
    cmd_t       act_log[$];
    done_t      exp_done[$];
    logic [7:0] rd_q[$];
    int         checks = 0, passes = 0;
    logic [7:0] model_data = '0;
    logic [1:0] model_ch = '0;
    logic       nack_arm = 1'b0;
    logic [7:0] nack_byte = '0;
    logic       saw_read = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act === want) passes++;
        else $display("FAIL %s: got %0h want %0h", name, act, want);
    endtask

    function automatic cmd_t mk(input logic [1:0] op, input logic [7:0] d, input logic m);
        cmd_t c;
        c.op = op; c.wdata = d; c.mack = m;
        return c;
    endfunction

    // Transaction grammar: what the device protocol requires for each request kind.
    task automatic exp_dac(input logic [7:0] v, input bit nack_addr);
        done_t d;
        exp_cmd.push_back(mk(START, 8'h00, 1'b0));
        exp_cmd.push_back(mk(WRITE, 8'h90, 1'b0));
        if (!nack_addr) begin
            exp_cmd.push_back(mk(WRITE, 8'h40, 1'b0));
            exp_cmd.push_back(mk(WRITE, v, 1'b0));
        end
        exp_cmd.push_back(mk(STOP, 8'h00, 1'b0));
        d.is_adc = 1'b0; d.err = nack_addr; d.data = '0; d.ch = '0;
        exp_done.push_back(d);
    endtask

    task automatic exp_adc(input logic [1:0] ch, input logic [7:0] stale, input logic [7:0] res,
                           input bit nack_ctrl);
        done_t d;
        exp_cmd.push_back(mk(START, 8'h00, 1'b0));
        exp_cmd.push_back(mk(WRITE, 8'h90, 1'b0));
        exp_cmd.push_back(mk(WRITE, 8'h40 + {6'b0, ch}, 1'b0));
        if (!nack_ctrl) begin
            exp_cmd.push_back(mk(START, 8'h00, 1'b0));
            exp_cmd.push_back(mk(WRITE, 8'h91, 1'b0));
            exp_cmd.push_back(mk(READ, 8'h00, 1'b1));
            exp_cmd.push_back(mk(READ, 8'h00, 1'b0));
            rd_q.push_back(stale);
            rd_q.push_back(res);
        end
        exp_cmd.push_back(mk(STOP, 8'h00, 1'b0));
        d.is_adc = 1'b1; d.err = nack_ctrl; d.data = res; d.ch = ch;
        exp_done.push_back(d);
    endtask

    // Byte-engine model: 0-5 cycle ready delay, response 20 cycles after acceptance.
    initial begin
        int dly, rcnt;
        logic [7:0] rd;
        logic nk, pv;
        cmd_t cur, pcmd, e;
        dly = -1; rcnt = 0; rd = '0; nk = 1'b0; pv = 1'b0; pcmd = '0;
        forever begin
            @(negedge clk);
            rsp_valid = 1'b0;
            rsp_nack  = 1'b0;
            if (!rst_n) begin
                cmd_ready = 1'b0; dly = -1; rcnt = 0; pv = 1'b0;
                continue;
            end
            cur = mk(cmd_op, cmd_wdata, cmd_mack);
            if (pv) begin
                check("cmd_held_valid", cmd_valid, 1'b1);
                check("cmd_stable", cur, pcmd);
            end
            if (cmd_ready) begin
                cmd_ready = 1'b0;
                rcnt = 20;
            end else if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0) begin
                    rsp_valid = 1'b1; rsp_rdata = rd; rsp_nack = nk;
                end
            end else if (cmd_valid) begin
                if (dly < 0) dly = $urandom_range(0, 5);
                if (dly == 0) begin
                    cmd_ready = 1'b1;
                    dly = -1;
                    act_log.push_back(cur);
                    nk = 1'b0;
                    if (cur.op == READ) begin
                        rd = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hEE;
                        saw_read = 1'b1;
                    end
                    if (cur.op == WRITE && nack_arm && cur.wdata == nack_byte) begin
                        nk = 1'b1; nack_arm = 1'b0;
                    end
                    if (exp_cmd.size() == 0) begin
                        checks++;
                        $display("FAIL cmd_unexpected: got op %0d data %0h want no command", cur.op, cur.wdata);
                    end else begin
                        e = exp_cmd.pop_front();
                        check("cmd_op", cur.op, e.op);
                        if (e.op == WRITE) check("cmd_wdata", cur.wdata, e.wdata);
                        if (e.op == READ)  check("cmd_mack", cur.mack, e.mack);
                    end
                end else begin
                    dly--;
                end
            end
            pv = cmd_valid && !cmd_ready;
            pcmd = cur;
        end
    end

    // Completion / held-output checker.
    initial begin
        done_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) continue;
            if (dac_done || adc_valid) begin
                check("single_pulse", {dac_done, adc_valid}, (adc_valid ? 2'b01 : 2'b10));
                check("busy_in_done", busy, 1'b1);
                if (exp_done.size() == 0) begin
                    checks++;
                    $display("FAIL done_unexpected: got adc_valid=%0b dac_done=%0b want none", adc_valid, dac_done);
                end else begin
                    e = exp_done.pop_front();
                    check("done_kind", adc_valid, e.is_adc);
                    check("done_err", err, e.err);
                    if (e.is_adc && !e.err) begin
                        model_data = e.data;
                        model_ch   = e.ch;
                    end
                end
            end else begin
                check("err_idle", err, 1'b0);
            end
            check("adc_held", {adc_ch_out, adc_data}, {model_ch, model_data});
        end
    end

    task automatic pulse(input bit d, input logic [7:0] dv, input bit a, input logic [1:0] ac);
        @(posedge clk); #2;
        dac_req = d; dac_value = dv; adc_req = a; adc_ch = ac;
        @(posedge clk); #2;
        dac_req = 1'b0; adc_req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (exp_cmd.size() == 0 && exp_done.size() == 0) break;
        end
        check({name, "_outstanding"}, exp_cmd.size() + exp_done.size(), 0);
        check({name, "_busy_after"}, busy, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        exp_cmd.delete(); exp_done.delete(); rd_q.delete();
        model_data = '0; model_ch = '0; nack_arm = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {dac_done, adc_valid, err, busy, cmd_valid, adc_data, adc_ch_out}, 0);
        @(posedge clk); #2 rst_n = 1'b1;

        // DAC write of 0x80
        act_log.delete();
        exp_dac(8'h80, 0);
        pulse(1, 8'h80, 0, 0);
        wait_idle("dac80");
        check("dac80_ncmds", act_log.size(), 5);
        if (act_log.size() == 5) begin
            check("dac80_c0", act_log[0].op, START);
            check("dac80_c1", {act_log[1].op, act_log[1].wdata}, {WRITE, 8'h90});
            check("dac80_c2", {act_log[2].op, act_log[2].wdata}, {WRITE, 8'h40});
            check("dac80_c3", {act_log[3].op, act_log[3].wdata}, {WRITE, 8'h80});
            check("dac80_c4", act_log[4].op, STOP);
        end

        // ADC channel 2, stale 0x11 then 0x5A
        act_log.delete();
        exp_adc(2'd2, 8'h11, 8'h5A, 0);
        pulse(0, 0, 1, 2'd2);
        wait_idle("adc2");
        check("adc2_data", adc_data, 8'h5A);
        check("adc2_ch", adc_ch_out, 2'd2);
        if (act_log.size() == 8) begin
            check("adc2_ctrl", act_log[2].wdata, 8'h42);
            check("adc2_rstart", act_log[3].op, START);
            check("adc2_raddr", act_log[4].wdata, 8'h91);
            check("adc2_rd_ack", {act_log[5].op, act_log[5].mack}, {READ, 1'b1});
            check("adc2_rd_nack", {act_log[6].op, act_log[6].mack}, {READ, 1'b0});
        end else check("adc2_ncmds", act_log.size(), 8);

        // Tie after reset: DAC wins; DAC re-requested during it, so the next tie goes to ADC
        do_reset();
        exp_dac(8'h33, 0);
        exp_adc(2'd1, 8'h11, 8'h5A, 0);
        exp_dac(8'h44, 0);
        pulse(1, 8'h33, 1, 2'd1);
        repeat (10) @(posedge clk);
        pulse(1, 8'h44, 0, 0);
        wait_idle("tie");
        check("tie_adc_data", adc_data, 8'h5A);

        // NACK on DAC address byte
        act_log.delete();
        nack_byte = 8'h90; nack_arm = 1'b1;
        exp_dac(8'h66, 1);
        pulse(1, 8'h66, 0, 0);
        wait_idle("dac_nack");
        check("dac_nack_ncmds", act_log.size(), 3);

        // NACK on ADC control byte keeps previous result
        nack_byte = 8'h43; nack_arm = 1'b1;
        exp_adc(2'd3, 8'h00, 8'h00, 1);
        pulse(0, 0, 1, 2'd3);
        wait_idle("adc_nack");
        check("adc_nack_data_kept", adc_data, 8'h5A);
        check("adc_nack_ch_kept", adc_ch_out, 2'd1);

        // Two DAC requests during ADC coalesce to the later value
        act_log.delete();
        exp_adc(2'd0, 8'h22, 8'h9C, 0);
        exp_dac(8'h20, 0);
        pulse(0, 0, 1, 2'd0);
        repeat (5) @(posedge clk);
        pulse(1, 8'h10, 0, 0);
        repeat (5) @(posedge clk);
        pulse(1, 8'h20, 0, 0);
        wait_idle("coalesce");
        check("coalesce_ncmds", act_log.size(), 13);
        if (act_log.size() == 13) check("coalesce_data", act_log[11].wdata, 8'h20);

        // Reset during an ADC read
        saw_read = 1'b0;
        exp_adc(2'd1, 8'h33, 8'h77, 0);
        pulse(0, 0, 1, 2'd1);
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (saw_read) break;
        end
        check("rst_saw_read", saw_read, 1'b1);
        #1 rst_n = 1'b0;
        exp_cmd.delete(); exp_done.delete(); rd_q.delete();
        model_data = '0; model_ch = '0;
        @(posedge clk); #1;
        check("rst_mid_outputs", {cmd_valid, busy, dac_done, adc_valid, err, adc_data, adc_ch_out}, 0);
        @(posedge clk); #2 rst_n = 1'b1;

        act_log.delete();
        exp_dac(8'h55, 0);
        pulse(1, 8'h55, 0, 0);
        wait_idle("post_rst");
        check("post_rst_data", (act_log.size() == 5) ? act_log[3].wdata : 8'h00, 8'h55);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
